sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder.sv | 133 +++++++++++++
 tb/tb_sram_like_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// ---------------------------------------------------------------------------
// sram_like_responder
//
// Behavioural SRAM-like slave with a split address/data handshake. Requests
// are accepted with addr_ok and answered, strictly in order, with data_ok.
// An internal 16-bit LFSR can throttle both handshakes pseudo-randomly so
// that initiators get exercised against stalls.
//
// Parameters
//   AW      word-address width; memory holds 2^AW 32-bit words
//   QDEPTH  maximum number of accepted but unanswered requests (power of 2)
//   SEED    reset value of the delay LFSR (must be nonzero)
//
// Ports
//   clk      in   1   clock, rising edge
//   resetn   in   1   synchronous active-low reset
//   req      in   1   request valid
//   wr       in   1   1 = write, 0 = read
//   size     in   2   access size (does not affect strobes or data placement)
//   wstrb    in   4   byte-write strobes for writes
//   addr     in   32  byte address, addr[AW+1:2] selects the word
//   wdata    in   32  write data
//   rand_en  in   1   enable pseudo-random handshake delays
//   addr_ok  out  1   request accepted this cycle when req=1
//   data_ok  out  1   one response returned this cycle
//   rdata    out  32  response data, zero when data_ok=0
// ---------------------------------------------------------------------------
module sram_like_responder #(
  parameter int unsigned AW     = 10,
  parameter int unsigned QDEPTH = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rand_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned   PW   = $clog2(QDEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   mem    [0:(1<<AW)-1];
  logic [31:0]   q_data [0:QDEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic          agate;
  logic          dgate;
  logic          push;
  logic          pop;
  logic [AW-1:0] word_idx;
  logic          unused_bits;

  assign word_idx = addr[AW+1:2];

  // size and the byte offset never change what is stored or returned;
  // they are folded together here only to show they are intentionally ignored.
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  // Handshake gating. addr_ok looks only at the count, never at data_ok, so a
  // full queue refuses new requests even in a cycle where the head drains.
  // Both gates open fully when rand_en is low.
  always_comb begin
    agate   = 1'b1;
    dgate   = 1'b1;
    if (rand_en) begin
      agate = lfsr[0];
      dgate = lfsr[8];
    end
    addr_ok = resetn && (count < FULL) && agate;
    data_ok = resetn && (count != '0) && dgate;
    rdata   = data_ok ? q_data[rd_ptr] : 32'h0;
    push    = req && addr_ok;
    pop     = data_ok;
    lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  end

  // Memory array: writes land on the accept edge, byte by byte under wstrb.
  // Contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response storage: a read captures the word as it stood before this edge
  // (earlier writes are already visible), a write queues a zero entry.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= wr ? 32'h0 : mem[word_idx];
    end
  end

  // Queue bookkeeping and the free-running LFSR. Pointers wrap naturally
  // because QDEPTH is a power of two. Reset throws away every pending entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lfsr   <= SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_like_responder
//
// Directed and randomized bench for sram_like_responder. A reference model
// (queue of pending responses, word array, LFSR stepped from its polynomial)
// predicts every handshake and response each cycle.
// ---------------------------------------------------------------------------
module tb_sram_like_responder;

  localparam int          AW     = 10;
  localparam int          QDEPTH = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rand_en;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [31:0] m_q[$];
  logic [31:0] m_mem [0:(1<<AW)-1];
  bit          m_synced = 1'b0;

  // Observations gathered for directed checks
  logic [31:0] obs_q[$];
  int          addr_stalls = 0;
  int          data_stalls = 0;
  bit          last_accept;

  sram_like_responder #(.AW(AW), .QDEPTH(QDEPTH), .SEED(SEED)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .rand_en (rand_en),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hang guard in case the run never reaches its summary
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form: taps at bits 0,2,3,5
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs with the model mid-cycle,
  // then advance the model across the upcoming rising edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [1:0] sz,
                               input logic [3:0] strb, input logic [31:0] a,
                               input logic [31:0] d, input logic re, input logic rn);
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
    int          idx;
    req     = r;
    wr      = w;
    size    = sz;
    wstrb   = strb;
    addr    = a;
    wdata   = d;
    rand_en = re;
    resetn  = rn;
    #2;
    e_aok   = rn && (m_q.size() < QDEPTH) && (re ? m_lfsr[0] : 1'b1);
    e_dok   = rn && (m_q.size() > 0) && (re ? m_lfsr[8] : 1'b1);
    e_rdata = e_dok ? m_q[0] : 32'h0;
    checkOutput("addr_ok", {31'b0, addr_ok}, {31'b0, e_aok});
    checkOutput("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
    checkOutput("rdata", rdata, e_rdata);
    if (m_synced) checkOutput("count", 32'(dut.count), 32'(m_q.size()));
    if (data_ok) obs_q.push_back(rdata);
    if (re && r && !addr_ok) addr_stalls++;
    if (re && rn && m_q.size() > 0 && !data_ok) data_stalls++;
    last_accept = r && e_aok;
    if (!rn) begin
      m_q.delete();
      m_lfsr   = SEED;
      m_synced = 1'b1;
    end else begin
      m_lfsr = lfsrNext(m_lfsr);
      if (e_dok) void'(m_q.pop_front());
      if (r && e_aok) begin
        idx = int'(a[AW+1:2]);
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (strb[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
          m_q.push_back(32'h0);
        end else begin
          m_q.push_back(m_mem[idx]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic re);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, re, 1'b1);
  endtask

  task automatic writeReq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb, input logic re);
    applyStimulus(1'b1, 1'b1, 2'd2, strb, a, d, re, 1'b1);
  endtask

  task automatic readReq(input logic [31:0] a, input logic re);
    applyStimulus(1'b1, 1'b0, 2'd2, 4'h0, a, 32'h0, re, 1'b1);
  endtask

  initial begin
    int          accepted;
    int          cycles;
    logic [31:0] exp_word;

    // Reset: everything quiet while resetn is low
    applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b0);

    // Full-word write then read at 0x40
    obs_q.delete();
    writeReq(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
    checkOutput("wr40_accept", {31'b0, last_accept}, 32'd1);
    readReq(32'h40, 1'b0);
    checkOutput("rd40_accept", {31'b0, last_accept}, 32'd1);
    idle(1'b0);
    idle(1'b0);
    checkOutput("rd40_resp_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) checkOutput("rd40_data", obs_q[1], 32'hDEADBEEF);

    // Partial strobes merge into an existing word
    obs_q.delete();
    writeReq(32'h80, 32'h11223344, 4'hF, 1'b0);
    writeReq(32'h80, 32'hAABBCCDD, 4'b0101, 1'b0);
    readReq(32'h80, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("strb_resp_count", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) checkOutput("strb_merge", obs_q[2], 32'h11BB33DD);

    // Six back-to-back reads with req held high
    for (int i = 0; i < 6; i++) writeReq(32'(4 * i), 32'hA5000000 | 32'(i), 4'hF, 1'b0);
    idle(1'b0);
    obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      readReq(32'(4 * i), 1'b0);
      checkOutput("b2b_accept", {31'b0, last_accept}, 32'd1);
    end
    idle(1'b0);
    idle(1'b0);
    checkOutput("b2b_resp_count", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() == 6)
      for (int i = 0; i < 6; i++) checkOutput("b2b_data", obs_q[i], 32'hA5000000 | 32'(i));

    // Randomized traffic over 16 preloaded words with pseudo-random stalls
    for (int k = 0; k < 16; k++) writeReq(32'h100 + 32'(4 * k), $urandom, 4'hF, 1'b0);
    idle(1'b0);
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      applyStimulus($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    4'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
                    $urandom, $urandom_range(0, 15) != 0, 1'b1);
      if (last_accept) accepted++;
      cycles++;
    end
    checkOutput("rand_accepts", 32'(accepted), 32'd1000);
    cycles = 0;
    while (m_q.size() > 0 && cycles < 200) begin
      idle(1'b1);
      cycles++;
    end
    checkOutput("rand_drained", 32'(m_q.size()), 32'd0);
    checkOutput("addr_stall_seen", {31'b0, addr_stalls > 0}, 32'd1);
    checkOutput("data_stall_seen", {31'b0, data_stalls > 0}, 32'd1);

    // Reset while reads are pending: those responses must vanish
    accepted = 0;
    cycles   = 0;
    while (accepted < 3 && cycles < 100) begin
      readReq(32'h100, 1'b1);
      if (last_accept) accepted++;
      cycles++;
    end
    checkOutput("pre_reset_accepts", 32'(accepted), 32'd3);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    obs_q.delete();
    for (int i = 0; i < 4; i++) idle(1'b0);
    checkOutput("post_reset_silent", 32'(obs_q.size()), 32'd0);
    exp_word = m_mem[64];
    readReq(32'h100, 1'b0);
    readReq(32'h40, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("post_reset_resp_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      checkOutput("post_reset_read", obs_q[0], exp_word);
      checkOutput("mem_persist", obs_q[1], 32'hDEADBEEF);
    end

    // Requests offered only while refused leave no trace
    obs_q.delete();
    for (int i = 0; i < 40; i++)
      applyStimulus(!m_lfsr[0], 1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    checkOutput("refused_no_resp", 32'(obs_q.size()), 32'd0);
    checkOutput("refused_count", 32'(dut.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
